// File: rtl/serial_add_ctrl_if.sv
// Request/result bus of the serial adder sequencer.
// The requester is master; the sequencer is slave.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, op_a, op_b, cin_in,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, op_a, op_b, cin_in,
    output ready, busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder built on an external 2-bit slice.
// Digits go LSB first; the carry is chained through carry_q.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  serial_add_ctrl_if.slave bus,
  output logic [1:0] slice_a,
  output logic [1:0] slice_b,
  output logic       slice_cin,
  input  logic [1:0] slice_s,
  input  logic       slice_cout
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;

  logic             run;
  logic [WIDTH-1:0] sum_d;

  assign run = (state_q == RUN);
  // New digit enters at the top; after DIGITS shifts it sits in place.
  assign sum_d = (sum_q >> 2) | (WIDTH'(slice_s) << (WIDTH - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            carry_q <= bus.cin_in;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 2;
          b_q     <= b_q >> 2;
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q  <= slice_cout;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slice_a   = run ? a_q[1:0] : 2'b00;
  assign slice_b   = run ? b_q[1:0] : 2'b00;
  assign slice_cin = run ? carry_q : 1'b0;

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = run;
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural
// 2-bit adder slice.
module tb_serial_add_ctrl;
  localparam int W = 8;
  localparam int DIGITS = W / 2;

  typedef struct {
    logic [W:0] res;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] slice_a;
  logic [1:0] slice_b;
  logic       slice_cin;
  logic [1:0] slice_s;
  logic       slice_cout;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_s    (slice_s),
    .slice_cout (slice_cout)
  );

  assign {slice_cout, slice_s} =
    {1'b0, slice_a} + {1'b0, slice_b} + {2'b00, slice_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_done = -1;
  bit   gap_on = 1'b0;
  exp_t sb[$];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", 32'(bus.sum), 32'(e.res[W-1:0]));
        chk("cout", 32'(bus.cout), 32'(e.res[W]));
        chk("latency", 32'(cyc - e.acc), 32'(DIGITS));
      end
      if (gap_on && last_done >= 0)
        chk("done_gap", 32'(cyc - last_done), 32'(DIGITS + 2));
      last_done = cyc;
    end
  end

  // Called at a negedge while the DUT is idle.
  task automatic push_exp(logic [W-1:0] a, logic [W-1:0] b,
                          logic c, int acc);
    exp_t e;
    e.res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic do_add(logic [W-1:0] a, logic [W-1:0] b,
                        logic c);
    push_exp(a, b, c, cyc + 1);
    bus.op_a   = a;
    bus.op_b   = b;
    bus.cin_in = c;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.ready) ok = 1'b1;
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    bit seen;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.cin_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("idle_slice_a", 32'(slice_a), 32'd0);
    @(negedge clk);

    // 12 + 34, then ready must return right after done
    do_add(8'h12, 8'h34, 1'b0);
    chk("run_busy", 32'(bus.busy), 32'd1);
    chk("run_ready", 32'(bus.ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("ready_after_done", 32'(bus.ready), 32'd1);
    wait_idle("t1");

    // Full carry ripple
    do_add(8'hFF, 8'h01, 1'b0);
    wait_idle("t2");
    do_add(8'hA5, 8'h5A, 1'b1);
    wait_idle("t3");

    // Digit order on the slice
    do_add(8'hE4, 8'h00, 1'b0);
    for (int i = 0; i < DIGITS; i++) begin
      logic [7:0] v;
      v = 8'hE4;
      chk("slice_a_seq", 32'(slice_a), 32'(v[2*i +: 2]));
      chk("slice_cin_seq", 32'(slice_cin), 32'd0);
      @(negedge clk);
    end
    wait_idle("t4");

    // Start and operand changes during RUN are ignored
    do_add(8'h12, 8'h34, 1'b0);
    bus.op_a   = 8'hFF;
    bus.op_b   = 8'h77;
    bus.cin_in = 1'b1;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op_a   = 8'h3C;
    wait_idle("t5");

    // Reset in the second RUN cycle abandons the add
    do_add(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_sum", 32'(bus.sum), 32'd0);
    chk("mid_rst_cout", 32'(bus.cout), 32'd0);
    repeat (8) @(negedge clk);
    do_add(8'h0F, 8'h01, 1'b0);
    wait_idle("t6");

    // start held high: back-to-back adds
    last_done  = -1;
    gap_on     = 1'b1;
    bus.op_a   = 8'h80;
    bus.op_b   = 8'h80;
    bus.cin_in = 1'b0;
    for (int k = 0; k < 3; k++)
      push_exp(8'h80, 8'h80, 1'b0, cyc + 1 + k * (DIGITS + 2));
    bus.start = 1'b1;
    repeat (2 * (DIGITS + 2) + 1) @(negedge clk);
    bus.start = 1'b0;
    wait_idle("t7");
    gap_on = 1'b0;
    chk("b2b_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
